// File: rtl/irq_prio_router_pkg.sv
// rtl/irq_prio_router_pkg.sv - route entry layout, entry type and cfg address map for irq_prio_router
package irq_prio_router_pkg;

    localparam int RT_EN_BIT    = 7;
    localparam int RT_EDGE_BIT  = 6;
    localparam int RT_PRIO_LSB  = 4;
    localparam int RT_PRIO_W    = 2;
    localparam int RT_LINE_LSB  = 0;
    localparam int RT_LINE_W    = 4;

    localparam int ADDR_STATUS_BASE = 'hF0;
    localparam int ADDR_MISROUTE    = 'hFF;

    typedef struct packed {
        logic       en;
        logic       edge_mode;
        logic [1:0] prio;
        logic [3:0] line;
    } route_entry_t;

    function automatic route_entry_t unpack_route(input logic [31:0] w);
        route_entry_t r;
        r.en        = w[RT_EN_BIT];
        r.edge_mode = w[RT_EDGE_BIT];
        r.prio      = w[RT_PRIO_LSB +: RT_PRIO_W];
        r.line      = w[RT_LINE_LSB +: RT_LINE_W];
        return r;
    endfunction

endpackage

// File: rtl/irq_line_arb.sv
// rtl/irq_line_arb.sv - per-CPU-line priority arbiter and grant FSM; round-robin ties under IRQ_PRIO_ROUTER_RR_EN
module irq_line_arb
    import irq_prio_router_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int SRC_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   cand_i,
    input  logic [2*NUM_SRC-1:0] prio_i,
    input  logic [NUM_SRC-1:0]   edge_i,
    input  logic [NUM_SRC-1:0]   wr_hit_i,
    input  logic                 ack_i,
    output logic                 active_o,
    output logic [SRC_W-1:0]     vector_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SRC_W-1:0] vec_q, vec_d;
    logic [SRC_W-1:0] start;
    logic [NUM_SRC-1:0] elig;
    logic             found;
    logic [SRC_W-1:0] pick;
    logic [1:0]       best;

`ifdef IRQ_PRIO_ROUTER_RR_EN
    logic [SRC_W-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // A source being rewritten this cycle must not be granted against its stale entry.
    assign elig = cand_i & ~wr_hit_i;

    // Scan in rotated order from start; strict '>' keeps the first of equal-priority ties.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_l;
        found = 1'b0;
        pick  = '0;
        best  = '0;
        idx   = 0;
        idx_l = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx_l = SRC_W'(idx);
            if (elig[idx_l] && (!found || prio_i[{idx_l, 1'b0} +: 2] > best)) begin
                found = 1'b1;
                best  = prio_i[{idx_l, 1'b0} +: 2];
                pick  = idx_l;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
`ifdef IRQ_PRIO_ROUTER_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_ACTIVE;
                    vec_d   = pick;
`ifdef IRQ_PRIO_ROUTER_RR_EN
                    ptr_d   = (pick == SRC_W'(NUM_SRC - 1)) ? '0 : pick + 1'b1;
`endif
                end
            end
            ST_ACTIVE: begin
                if (!cand_i[vec_q] || wr_hit_i[vec_q] || (ack_i && edge_i[vec_q]))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
`ifdef IRQ_PRIO_ROUTER_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
`ifdef IRQ_PRIO_ROUTER_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign active_o = (state_q == ST_ACTIVE);
    assign vector_o = vec_q;

endmodule

// File: rtl/irq_prio_router.sv
// rtl/irq_prio_router.sv - dock interrupt router top: cfg entries, pending, per-line arbiters, NMI; IRQ_PRIO_ROUTER_RR_EN selects round-robin ties
module irq_prio_router
    import irq_prio_router_pkg::*;
#(
    parameter  int NUM_SLOTS       = 4,
    parameter  int NUM_TILE_INT_CH = 2,
    parameter  int NUM_CPU_INT     = 2,
    parameter  int NUM_CPU_NMI     = 1,
    parameter  int CFG_ADDR_WIDTH  = 8,
    localparam int NUM_SRC         = NUM_SLOTS * NUM_TILE_INT_CH,
    localparam int SRC_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           tile_int_req,
    input  logic [NUM_SLOTS-1:0]         tile_nmi_req,
    input  logic [NUM_CPU_INT-1:0]       irq_ack,
    output logic [NUM_CPU_INT-1:0]       cpu_int,
    output logic [NUM_CPU_NMI-1:0]       cpu_nmi,
    output logic [NUM_SLOTS-1:0]         slot_ack,
    output logic [NUM_CPU_INT-1:0]       int_active,
    output logic [NUM_CPU_INT*SRC_W-1:0] int_vector,
    input  logic                         cfg_wr_en,
    input  logic                         cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]    cfg_addr,
    input  logic [31:0]                  cfg_wdata,
    output logic [31:0]                  cfg_rdata
);

    logic [NUM_SRC-1:0]   req_q, req_prev_q;
    logic [NUM_SRC-1:0]   pend_edge_q, pend_edge_d;
    logic [NUM_SLOTS-1:0] nmi_q;
    route_entry_t         route_q [NUM_SRC];
    route_entry_t         nmi_entry_q [NUM_SLOTS];
    route_entry_t         wr_entry, nmi_wr_entry;
    logic                 misroute_q, misroute_d, misroute_set;
    logic [NUM_SLOTS-1:0] slot_ack_q, slot_ack_d;
    logic [NUM_CPU_NMI-1:0] cpu_nmi_q, cpu_nmi_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [NUM_SRC-1:0]   wr_hit, rise, pending, ack_clr, edge_flags;
    logic [NUM_SLOTS-1:0] nmi_wr_hit;
    logic [2*NUM_SRC-1:0] prio_flat;
    logic [NUM_CPU_INT-1:0][NUM_SRC-1:0] line_cand;
    logic [NUM_CPU_INT-1:0]              line_active;
    logic [NUM_CPU_INT-1:0][SRC_W-1:0]   line_vec;

    always_comb begin
        wr_entry     = unpack_route(cfg_wdata);
        nmi_wr_entry = wr_entry;
        nmi_wr_entry.edge_mode = 1'b0;
        nmi_wr_entry.prio      = '0;
        for (int s = 0; s < NUM_SRC; s++)
            wr_hit[s] = cfg_wr_en && (int'(cfg_addr) == s);
        for (int sl = 0; sl < NUM_SLOTS; sl++)
            nmi_wr_hit[sl] = cfg_wr_en && (int'(cfg_addr) == NUM_SRC + sl);
    end

    // Edge sources see their rising edge combinationally so both modes share the same grant latency.
    always_comb begin
        rise = req_q & ~req_prev_q;
        for (int s = 0; s < NUM_SRC; s++) begin
            pending[s] = route_q[s].en &&
                         (route_q[s].edge_mode ? (pend_edge_q[s] | rise[s]) : req_q[s]);
        end
    end

    always_comb begin
        ack_clr    = '0;
        slot_ack_d = '0;
        for (int k = 0; k < NUM_CPU_INT; k++) begin
            if (line_active[k] && irq_ack[k]) begin
                for (int s = 0; s < NUM_SRC; s++)
                    if (int'(line_vec[k]) == s) ack_clr[s] = 1'b1;
                for (int sl = 0; sl < NUM_SLOTS; sl++)
                    if (int'(line_vec[k]) / NUM_TILE_INT_CH == sl) slot_ack_d[sl] = 1'b1;
            end
        end
    end

    // A cfg write to a source discards any edge captured in the same cycle.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (wr_hit[s] || !route_q[s].en || !route_q[s].edge_mode)
                pend_edge_d[s] = 1'b0;
            else
                pend_edge_d[s] = (pend_edge_q[s] & ~ack_clr[s]) | rise[s];
        end
    end

    always_comb begin
        line_cand    = '0;
        misroute_set = 1'b0;
        prio_flat    = '0;
        edge_flags   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            prio_flat[2*s +: 2] = route_q[s].prio;
            edge_flags[s]       = route_q[s].edge_mode;
            if (pending[s] && int'(route_q[s].line) >= NUM_CPU_INT)
                misroute_set = 1'b1;
            for (int k = 0; k < NUM_CPU_INT; k++)
                if (pending[s] && int'(route_q[s].line) == k) line_cand[k][s] = 1'b1;
        end
        misroute_d = (misroute_q &&
                      !(cfg_wr_en && int'(cfg_addr) == ADDR_MISROUTE && cfg_wdata[0])) ||
                     misroute_set;
    end

    always_comb begin
        for (int j = 0; j < NUM_CPU_NMI; j++) begin
            cpu_nmi_d[j] = 1'b0;
            for (int sl = 0; sl < NUM_SLOTS; sl++)
                if (nmi_q[sl] && nmi_entry_q[sl].en && int'(nmi_entry_q[sl].line) == j)
                    cpu_nmi_d[j] = 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cfg_rd_en) begin
            rdata_d = '0;
            for (int s = 0; s < NUM_SRC; s++)
                if (int'(cfg_addr) == s) rdata_d = {24'b0, route_q[s]};
            for (int sl = 0; sl < NUM_SLOTS; sl++)
                if (int'(cfg_addr) == NUM_SRC + sl) rdata_d = {24'b0, nmi_entry_q[sl]};
            for (int k = 0; k < NUM_CPU_INT; k++)
                if (int'(cfg_addr) == ADDR_STATUS_BASE + k)
                    rdata_d = {24'b0, line_active[k], 7'(line_vec[k])};
            if (int'(cfg_addr) == ADDR_MISROUTE) rdata_d = {31'b0, misroute_q};
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            req_q       <= '0;
            req_prev_q  <= '0;
            nmi_q       <= '0;
            pend_edge_q <= '0;
            misroute_q  <= 1'b0;
            slot_ack_q  <= '0;
            cpu_nmi_q   <= '0;
            rdata_q     <= '0;
            for (int s = 0; s < NUM_SRC; s++) route_q[s] <= '0;
            for (int sl = 0; sl < NUM_SLOTS; sl++) nmi_entry_q[sl] <= '0;
        end else begin
            req_q       <= tile_int_req;
            req_prev_q  <= req_q;
            nmi_q       <= tile_nmi_req;
            pend_edge_q <= pend_edge_d;
            misroute_q  <= misroute_d;
            slot_ack_q  <= slot_ack_d;
            cpu_nmi_q   <= cpu_nmi_d;
            rdata_q     <= rdata_d;
            for (int s = 0; s < NUM_SRC; s++)
                if (wr_hit[s]) route_q[s] <= wr_entry;
            for (int sl = 0; sl < NUM_SLOTS; sl++)
                if (nmi_wr_hit[sl]) nmi_entry_q[sl] <= nmi_wr_entry;
        end
    end

    for (genvar k = 0; k < NUM_CPU_INT; k++) begin : g_line
        irq_line_arb #(
            .NUM_SRC (NUM_SRC),
            .SRC_W   (SRC_W)
        ) u_arb (
            .clk      (clk),
            .rst_n    (rst_n),
            .cand_i   (line_cand[k]),
            .prio_i   (prio_flat),
            .edge_i   (edge_flags),
            .wr_hit_i (wr_hit),
            .ack_i    (irq_ack[k]),
            .active_o (line_active[k]),
            .vector_o (line_vec[k])
        );
    end

    assign cpu_int    = line_active;
    assign int_active = line_active;
    assign int_vector = line_vec;
    assign cpu_nmi    = cpu_nmi_q;
    assign slot_ack   = slot_ack_q;
    assign cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_irq_prio_router.sv
// tb/tb_irq_prio_router.sv - directed self-checking bench for irq_prio_router
module tb_irq_prio_router;

    localparam int NUM_SLOTS = 4;
    localparam int NUM_TILE_INT_CH = 2;
    localparam int NUM_CPU_INT = 2;
    localparam int NUM_CPU_NMI = 1;
    localparam int CFG_ADDR_WIDTH = 8;
    localparam int NUM_SRC = 8;
    localparam int SRC_W = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_SRC-1:0] tile_int_req;
    logic [NUM_SLOTS-1:0] tile_nmi_req;
    logic [NUM_CPU_INT-1:0] irq_ack;
    logic [NUM_CPU_INT-1:0] cpu_int;
    logic [NUM_CPU_NMI-1:0] cpu_nmi;
    logic [NUM_SLOTS-1:0] slot_ack;
    logic [NUM_CPU_INT-1:0] int_active;
    logic [NUM_CPU_INT*SRC_W-1:0] int_vector;
    logic cfg_wr_en, cfg_rd_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;

    int n_checks = 0;
    int n_fail = 0;

    irq_prio_router #(
        .NUM_SLOTS(NUM_SLOTS), .NUM_TILE_INT_CH(NUM_TILE_INT_CH), .NUM_CPU_INT(NUM_CPU_INT),
        .NUM_CPU_NMI(NUM_CPU_NMI), .CFG_ADDR_WIDTH(CFG_ADDR_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tile_int_req(tile_int_req), .tile_nmi_req(tile_nmi_req),
        .irq_ack(irq_ack), .cpu_int(cpu_int), .cpu_nmi(cpu_nmi), .slot_ack(slot_ack),
        .int_active(int_active), .int_vector(int_vector), .cfg_wr_en(cfg_wr_en),
        .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        cfg_addr = addr; cfg_wdata = data; cfg_wr_en = 1'b1;
        tick(1);
        cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] addr, output logic [31:0] data);
        cfg_addr = addr; cfg_rd_en = 1'b1;
        tick(1);
        cfg_rd_en = 1'b0;
        data = cfg_rdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; tile_int_req = '0; tile_nmi_req = '0; irq_ack = '0;
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        tick(3);
        n_checks++;
        if ({cpu_int, cpu_nmi, slot_ack, int_active, int_vector, cfg_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: int=%b nmi=%b sack=%b act=%b vec=%h rdata=%h expected all 0",
                     cpu_int, cpu_nmi, slot_ack, int_active, int_vector, cfg_rdata);
        end
        rst_n = 1'b0;
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b00) begin
            n_fail++; $display("FAIL reset_release: cpu_int=%b expected 00", cpu_int);
        end
    endtask

    task automatic test_level;
        logic [31:0] rd;
        cfg_write(8'd0, 32'h90);
        tile_int_req = 8'b0000_0001;
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b00) begin n_fail++; $display("FAIL level_latency: cpu_int=%b expected 00", cpu_int); end
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b01 || int_active !== 2'b01 || int_vector[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL level_grant: cpu_int=%b act=%b vec0=%0d expected 01 01 0", cpu_int, int_active, int_vector[2:0]);
        end
        cfg_read(8'hF0, rd);
        n_checks++;
        if (rd !== 32'h80) begin n_fail++; $display("FAIL status_line0: rdata=%h expected 80", rd); end
        tile_int_req = '0;
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b01) begin n_fail++; $display("FAIL level_release_lat: cpu_int=%b expected 01", cpu_int); end
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b00) begin n_fail++; $display("FAIL level_release: cpu_int=%b expected 00", cpu_int); end
    endtask

    task automatic test_priority;
        cfg_write(8'd2, 32'hB0);
        tile_int_req = 8'b0000_0101;
        tick(2);
        n_checks++;
        if (cpu_int !== 2'b01 || int_vector[2:0] !== 3'd2) begin
            n_fail++; $display("FAIL prio_high: cpu_int=%b vec0=%0d expected 01 2", cpu_int, int_vector[2:0]);
        end
        tile_int_req = 8'b0000_0001;
        tick(2);
        n_checks++;
        if (cpu_int !== 2'b00) begin n_fail++; $display("FAIL prio_gap: cpu_int=%b expected 00", cpu_int); end
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b01 || int_vector[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL prio_next: cpu_int=%b vec0=%0d expected 01 0", cpu_int, int_vector[2:0]);
        end
        tile_int_req = '0;
        tick(2);
    endtask

    task automatic test_ack_idle;
        irq_ack = 2'b01;
        tick(1);
        irq_ack = 2'b00;
        n_checks++;
        if (slot_ack !== 4'b0000) begin n_fail++; $display("FAIL ack_idle: slot_ack=%b expected 0000", slot_ack); end
        tick(1);
        n_checks++;
        if (slot_ack !== 4'b0000) begin n_fail++; $display("FAIL ack_idle_late: slot_ack=%b expected 0000", slot_ack); end
    endtask

    task automatic test_edge_ack;
        cfg_write(8'd1, 32'hD1);
        tile_int_req = 8'b0000_0010;
        tick(1);
        tile_int_req = '0;
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b10) begin n_fail++; $display("FAIL edge_grant: cpu_int=%b expected 10", cpu_int); end
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b10 || int_vector[5:3] !== 3'd1) begin
            n_fail++; $display("FAIL edge_held: cpu_int=%b vec1=%0d expected 10 1", cpu_int, int_vector[5:3]);
        end
        irq_ack = 2'b10;
        tick(1);
        irq_ack = 2'b00;
        n_checks++;
        if (slot_ack !== 4'b0001 || cpu_int !== 2'b00) begin
            n_fail++; $display("FAIL edge_ack: slot_ack=%b cpu_int=%b expected 0001 00", slot_ack, cpu_int);
        end
        tick(1);
        n_checks++;
        if (slot_ack !== 4'b0000 || cpu_int !== 2'b00) begin
            n_fail++; $display("FAIL edge_ack_pulse: slot_ack=%b cpu_int=%b expected 0000 00", slot_ack, cpu_int);
        end
    endtask

    task automatic test_dual_lines;
        cfg_write(8'd2, 32'h91);
        tile_int_req = 8'b0000_0101;
        tick(2);
        n_checks++;
        if (cpu_int !== 2'b11 || int_vector !== 6'b010_000) begin
            n_fail++; $display("FAIL dual_grant: cpu_int=%b vec=%b expected 11 010000", cpu_int, int_vector);
        end
        irq_ack = 2'b11;
        tick(1);
        irq_ack = 2'b00;
        n_checks++;
        if (slot_ack !== 4'b0011 || cpu_int !== 2'b11) begin
            n_fail++; $display("FAIL dual_level_ack: slot_ack=%b cpu_int=%b expected 0011 11", slot_ack, cpu_int);
        end
        tile_int_req = '0;
        tick(2);
        n_checks++;
        if (cpu_int !== 2'b00 || slot_ack !== 4'b0000) begin
            n_fail++; $display("FAIL dual_release: cpu_int=%b slot_ack=%b expected 00 0000", cpu_int, slot_ack);
        end
    endtask

    task automatic test_nmi;
        logic [31:0] rd;
        cfg_write(8'd9, 32'h80);
        tile_nmi_req = 4'b0010;
        tick(1);
        n_checks++;
        if (cpu_nmi !== 1'b0) begin n_fail++; $display("FAIL nmi_latency: cpu_nmi=%b expected 0", cpu_nmi); end
        tick(1);
        n_checks++;
        if (cpu_nmi !== 1'b1 || cpu_int !== 2'b00) begin
            n_fail++; $display("FAIL nmi_assert: cpu_nmi=%b cpu_int=%b expected 1 00", cpu_nmi, cpu_int);
        end
        tile_nmi_req = 4'b0100;
        tick(3);
        n_checks++;
        if (cpu_nmi !== 1'b0) begin n_fail++; $display("FAIL nmi_disabled_slot: cpu_nmi=%b expected 0", cpu_nmi); end
        tile_nmi_req = '0;
        cfg_read(8'd9, rd);
        n_checks++;
        if (rd !== 32'h80) begin n_fail++; $display("FAIL nmi_readback: rdata=%h expected 80", rd); end
        cfg_read(8'd1, rd);
        n_checks++;
        if (rd !== 32'hD1) begin n_fail++; $display("FAIL route_readback: rdata=%h expected d1", rd); end
    endtask

    task automatic test_misroute;
        logic [31:0] rd;
        cfg_write(8'd3, 32'h85);
        tile_int_req = 8'b0000_1000;
        tick(2);
        n_checks++;
        if (cpu_int !== 2'b00 || int_active !== 2'b00) begin
            n_fail++; $display("FAIL misroute_nogrant: cpu_int=%b act=%b expected 00 00", cpu_int, int_active);
        end
        tile_int_req = '0;
        tick(2);
        cfg_read(8'hFF, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL misroute_set: rdata=%h expected 1", rd); end
        cfg_write(8'hFF, 32'h1);
        cfg_read(8'hFF, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL misroute_clear: rdata=%h expected 0", rd); end
        cfg_read(8'hE0, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: rdata=%h expected 0", rd); end
    endtask

    task automatic test_round_robin_and_reset;
        logic [31:0] rd;
        logic [2:0] exp_second;
`ifdef IRQ_PRIO_ROUTER_RR_EN
        exp_second = 3'd1;
`else
        exp_second = 3'd0;
`endif
        rst_n = 1'b1;
        tick(2);
        rst_n = 1'b0;
        cfg_write(8'd0, 32'h90);
        cfg_write(8'd1, 32'h90);
        tile_int_req = 8'b0000_0011;
        tick(2);
        n_checks++;
        if (cpu_int !== 2'b01 || int_vector[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL tie_first: cpu_int=%b vec0=%0d expected 01 0", cpu_int, int_vector[2:0]);
        end
        cfg_write(8'd0, 32'h90);
        n_checks++;
        if (cpu_int !== 2'b00) begin n_fail++; $display("FAIL tie_release: cpu_int=%b expected 00", cpu_int); end
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b01 || int_vector[2:0] !== exp_second) begin
            n_fail++; $display("FAIL tie_second: cpu_int=%b vec0=%0d expected 01 %0d", cpu_int, int_vector[2:0], exp_second);
        end
        cfg_write({5'b0, exp_second}, 32'h90);
        tick(1);
        n_checks++;
        if (cpu_int !== 2'b01 || int_vector[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL tie_third: cpu_int=%b vec0=%0d expected 01 0", cpu_int, int_vector[2:0]);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cpu_int !== 2'b00 || int_active !== 2'b00 || int_vector !== 6'd0) begin
            n_fail++; $display("FAIL reset_mid_grant: cpu_int=%b act=%b vec=%b expected 00 00 0", cpu_int, int_active, int_vector);
        end
        tile_int_req = '0;
        tick(2);
        rst_n = 1'b0;
        cfg_read(8'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_entries: rdata=%h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_ack_idle();
        test_edge_ack();
        test_dual_lines();
        test_nmi();
        test_misroute();
        test_round_robin_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_prio_router.md
# irq_prio_router

Second-generation dock interrupt router: maps per-slot tile INT channels and NMI lines onto CPU interrupt pins, with an independent arbiter per CPU INT line. Adds programmable per-source priority, level/edge mode with ack-to-clear, round-robin tie-break and per-line vector readback. Sits between tile slot connectors and the CPU socket; configured over the dock cfg bus.

## Interface
- NUM_SLOTS, 4, tile slots
- NUM_TILE_INT_CH, 2, maskable INT channels per slot
- NUM_CPU_INT, 2, CPU INT pins (≤15)
- NUM_CPU_NMI, 1, CPU NMI pins (≤15)
- CFG_ADDR_WIDTH, 8, cfg address width
- NUM_SRC (derived), NUM_SLOTS*NUM_TILE_INT_CH; source s = slot*NUM_TILE_INT_CH + ch
- SRC_W (derived), $clog2(NUM_SRC), minimum 1

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- tile_int_req  in  NUM_SRC  maskable requests, flattened
- tile_nmi_req  in  NUM_SLOTS  NMI requests
- irq_ack  in  NUM_CPU_INT  per-line acknowledge strobe
- cpu_int  out  NUM_CPU_INT  INT pins, active-high
- cpu_nmi  out  NUM_CPU_NMI  NMI pins, active-high
- slot_ack  out  NUM_SLOTS  one-cycle ack pulse to owning slot
- int_active  out  NUM_CPU_INT  line k has a granted source
- int_vector  out  NUM_CPU_INT*SRC_W  granted source index per line
- cfg_wr_en, cfg_rd_en  in  1  cfg strobes
- cfg_addr  in  CFG_ADDR_WIDTH; cfg_wdata  in  32; cfg_rdata  out  32

## Operation
- INT route entry (addr s): [7] enable, [6] edge mode, [5:4] priority (3 highest), [3:0] cpu line. NMI entry (addr NUM_SRC+slot): [7] enable, [3:0] nmi line. 0xF0+k: read-only status line k {[7] active, [6:0] vector}. 0xFF: [0] sticky misroute, write-1-clear. Other addresses read 0, writes ignored.
- Inputs registered once (req_q). Level source pending = req_q & enable. Edge source: pending latched on req_q rising edge, cleared by ack while granted or by enable=0.
- Per-line FSM IDLE/ACTIVE. IDLE: among pending sources routed to line k pick highest priority; ties per Configuration; grant -> ACTIVE, latch vector. ACTIVE: cpu_int[k]=1. Exit to IDLE when granted source's pending drops, or its entry is rewritten (any value). No queuing beyond pending bits.
- irq_ack[k] in ACTIVE: slot_ack[vector/NUM_TILE_INT_CH] pulses next cycle; edge source clears and releases; level source stays ACTIVE. Ack in IDLE ignored. Simultaneous acks to lines owned by same slot OR into one pulse.
- Enabled source with cpu line ≥ NUM_CPU_INT: never granted, sets misroute.
- NMI: per NMI line, lowest enabled requesting slot wins; level only; cpu_nmi held while that request high. NMI independent of INT lines.

## Timing
- Reset: all outputs, pending, entries, vectors, rr pointers, cfg_rdata = 0.
- Request at edge N -> req_q N+1 -> cpu_int/cpu_nmi/int_active at N+2. Release: deassert at N -> cpu_int low at N+2.
- IDLE after release grants next pending in the same cycle it re-enters IDLE evaluation: ≥1 cycle of cpu_int low between grants.
- cfg_rdata valid cycle after cfg_rd_en; write effective next cycle. Write and edge-set same cycle on same source: write wins.
- Reset mid-grant: immediate drop of all outputs.

## Configuration
- IRQ_PRIO_ROUTER_RR_EN defined: per-line round-robin among equal-priority ties, pointer = last granted source +1, wraps at NUM_SRC.
- Undefined: lowest source index wins ties; no pointer state.

## Structure
- Package irq_prio_router_pkg: route entry field positions, route_entry_t struct, status/misroute address constants.
- Sub-module irq_line_arb: one instance per CPU INT line (selection, FSM, rr pointer).

## Test plan
- Route s0 line0 pri1 level; assert req -> cpu_int=01 two cycles later; deassert -> 00 two cycles later.
- s0 and s2 both line0, pri1 vs pri3 -> vector=2 first; release s2 -> vector=0.
- Edge s1 line1: 1-cycle pulse -> cpu_int=10 held; irq_ack[1] -> slot_ack=0001 one cycle, cpu_int=00.
- Level s0 on line0 plus s2 on line1 simultaneously -> cpu_int=11, vectors 0 and 2.
- Equal priority s0,s1 line0 held, repeated releases via reconfig -> alternates 0,1,0 with RR_EN; always 0 without.
- Route s3 to line 5 -> no cpu_int, 0xFF reads 1; write 1 -> reads 0.
